// File: rtl/closest_hit_selector_pkg.sv
// Shared types for the closest-hit selector: float format,
// scheduler states and the zero distance used for empty rays.
package closest_hit_selector_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } p_float;

   typedef enum logic [1:0] {
      S_ACCEPT,
      S_UPD,
      S_EMIT
   } sel_state_t;

   localparam p_float P_FLOAT_ZERO = '0;

endpackage

// File: rtl/greater_than.sv
// Registered strict a > b compare on p_float values, 1-cycle latency.
// +0 and -0 compare equal; NaN ordering is not defined.
module greater_than
   import closest_hit_selector_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  p_float a,
   input  p_float b,
   output logic   gt
);

   function automatic logic f_gt(input p_float x, input p_float y);
      logic xz;
      logic yz;
      xz = ({x.exp, x.mant} == '0);
      yz = ({y.exp, y.mant} == '0);
      if (xz && yz)
         return 1'b0;
      if (x.sign != y.sign)
         return !x.sign;
      // same sign: magnitude order, reversed for negatives
      if (!x.sign)
         return {x.exp, x.mant} > {y.exp, y.mant};
      return {x.exp, x.mant} < {y.exp, y.mant};
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         gt <= 1'b0;
      else
         gt <= f_gt(a, b);
   end

endmodule

// File: rtl/closest_hit_selector.sv
// Per-ray nearest-hit scheduler: streams candidates through one
// shared comparator and emits one result beat after in_last.
module closest_hit_selector
   import closest_hit_selector_pkg::*;
#(
   parameter int ID_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  p_float           in_t,
   input  logic [ID_W-1:0]  in_id,
   input  logic             in_is_hit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output p_float           out_t,
   output logic [ID_W-1:0]  out_id,
   output logic [CNT_W-1:0] out_count
);

   sel_state_t       state, nxt_state;
   logic             have_best, nxt_have;
   p_float           best_t, nxt_best_t;
   logic [ID_W-1:0]  best_id, nxt_best_id;
   logic [CNT_W-1:0] count, nxt_count, cnt_inc;
   p_float           cand_t, nxt_cand_t;
   logic [ID_W-1:0]  cand_id, nxt_cand_id;
   logic             cand_last, nxt_cand_last;
   logic             gt_res;
   logic             accept;
   logic             valid_cand;
   logic             load_out;

   greater_than u_gt (
      .clk (clk),
      .rst (rst),
      .a   (best_t),
      .b   (in_t),
      .gt  (gt_res)
   );

   assign in_ready   = (state == S_ACCEPT) & !rst;
   assign accept     = in_valid & in_ready;
   assign valid_cand = in_is_hit & !in_t.sign;
   assign cnt_inc    = (&count) ? count : count + 1'b1;

   always_comb begin
      nxt_state     = state;
      nxt_have      = have_best;
      nxt_best_t    = best_t;
      nxt_best_id   = best_id;
      nxt_count     = count;
      nxt_cand_t    = cand_t;
      nxt_cand_id   = cand_id;
      nxt_cand_last = cand_last;
      unique case (state)
         S_ACCEPT: begin
            if (accept) begin
               if (valid_cand && have_best) begin
                  nxt_cand_t    = in_t;
                  nxt_cand_id   = in_id;
                  nxt_cand_last = in_last;
                  nxt_count     = cnt_inc;
                  nxt_state     = S_UPD;
               end else begin
                  if (valid_cand) begin
                     nxt_best_t  = in_t;
                     nxt_best_id = in_id;
                     nxt_have    = 1'b1;
                     nxt_count   = CNT_W'(1);
                  end
                  if (in_last)
                     nxt_state = S_EMIT;
               end
            end
         end
         S_UPD: begin
            // strict compare keeps the earlier candidate on ties
            if (gt_res) begin
               nxt_best_t  = cand_t;
               nxt_best_id = cand_id;
            end
            nxt_state = cand_last ? S_EMIT : S_ACCEPT;
         end
         S_EMIT: begin
            if (out_ready) begin
               nxt_have  = 1'b0;
               nxt_count = '0;
               nxt_state = S_ACCEPT;
            end
         end
         default: nxt_state = S_ACCEPT;
      endcase
   end

   assign load_out = (state != S_EMIT) && (nxt_state == S_EMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_ACCEPT;
         have_best <= 1'b0;
         best_t    <= P_FLOAT_ZERO;
         best_id   <= '0;
         count     <= '0;
         cand_t    <= P_FLOAT_ZERO;
         cand_id   <= '0;
         cand_last <= 1'b0;
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_t     <= P_FLOAT_ZERO;
         out_id    <= '0;
         out_count <= '0;
      end else begin
         state     <= nxt_state;
         have_best <= nxt_have;
         best_t    <= nxt_best_t;
         best_id   <= nxt_best_id;
         count     <= nxt_count;
         cand_t    <= nxt_cand_t;
         cand_id   <= nxt_cand_id;
         cand_last <= nxt_cand_last;
         if (load_out) begin
            out_valid <= 1'b1;
            out_hit   <= nxt_have;
            out_t     <= nxt_have ? nxt_best_t : P_FLOAT_ZERO;
            out_id    <= nxt_have ? nxt_best_id : '0;
            out_count <= nxt_count;
         end else if (state == S_EMIT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
